// File: rtl/wt_scheduler_if.sv
// Signal bundle around wt_scheduler: requester streams, engine slave port and W(t) monitor.
// slave is the scheduler; master is the surrounding requesters, wt_unit and consumer.
interface wt_scheduler_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 512,
    parameter int ID_WIDTH   = 2,
    parameter int CNT_WIDTH  = 16
);
    logic [NUM_REQ*DATA_WIDTH-1:0] s_axis_tdata;
    logic [NUM_REQ-1:0]            s_axis_tvalid;
    logic [NUM_REQ-1:0]            s_axis_tready;
    logic [NUM_REQ-1:0]            s_axis_tlast;
    logic [2*NUM_REQ-1:0]          req_sha_type;

    logic [DATA_WIDTH-1:0]         m_axis_tdata;
    logic                          m_axis_tvalid;
    logic                          m_axis_tready;
    logic                          m_axis_tlast;
    logic                          eng_en;
    logic [1:0]                    eng_sha_type;

    logic                          wt_tvalid;
    logic                          wt_tready;
    logic                          wt_tlast;

    logic                          busy;
    logic [ID_WIDTH-1:0]           grant_id;
    logic                          msg_done;
    logic [ID_WIDTH-1:0]           done_id;
    logic [CNT_WIDTH-1:0]          msg_count;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, req_sha_type,
        input  m_axis_tready, wt_tvalid, wt_tready, wt_tlast,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output eng_en, eng_sha_type, busy, grant_id, msg_done, done_id, msg_count
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, req_sha_type,
        output m_axis_tready, wt_tvalid, wt_tready, wt_tlast,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  eng_en, eng_sha_type, busy, grant_id, msg_done, done_id, msg_count
    );
endinterface

// File: rtl/wt_scheduler.sv
// Round-robin, whole-message arbiter sharing one wt_unit among NUM_REQ block streams.
// A grant lasts from arbitration until the engine's final W(t) beat is consumed.
module wt_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 512,
    parameter int ID_WIDTH   = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic          axi_aclk,
    input  logic          axi_reset,
    wt_scheduler_if.slave bus
);
    // Per-requester views are padded to 2**ID_WIDTH slots so grant_id indexes them directly.
    localparam int NUM_SLOT = 1 << ID_WIDTH;

    typedef enum logic [1:0] {IDLE, START, STREAM, DRAIN} state_t;

    state_t                state;
    state_t                state_next;

    logic [DATA_WIDTH-1:0] req_data [NUM_SLOT];
    logic [1:0]            req_sha  [NUM_SLOT];
    logic [NUM_SLOT-1:0]   req_valid;
    logic [NUM_SLOT-1:0]   req_last;
    logic [NUM_SLOT-1:0]   ready_slot;

    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [ID_WIDTH-1:0]   grant_id;
    logic [ID_WIDTH-1:0]   done_id;
    logic [ID_WIDTH-1:0]   arb_idx;
    logic                  arb_found;
    logic [1:0]            eng_sha_type;
    logic                  busy;
    logic                  msg_done;
    logic [CNT_WIDTH-1:0]  msg_count;
    logic                  beat;
    logic                  wt_last_hs;

    for (genvar i = 0; i < NUM_SLOT; i++) begin : g_slot
        if (i < NUM_REQ) begin : g_used
            assign req_data[i] = bus.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            assign req_sha[i]  = bus.req_sha_type[2*i +: 2];
        end else begin : g_pad
            assign req_data[i] = '0;
            assign req_sha[i]  = '0;
        end
    end

    assign req_valid  = NUM_SLOT'(bus.s_axis_tvalid);
    assign req_last   = NUM_SLOT'(bus.s_axis_tlast);
    assign beat       = bus.m_axis_tvalid & bus.m_axis_tready;
    assign wt_last_hs = bus.wt_tvalid & bus.wt_tready & bus.wt_tlast;

    // Cyclic search starting just after the previous owner.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!arb_found && req_valid[ID_WIDTH'((int'(rr_ptr) + k) % NUM_REQ)]) begin
                arb_found = 1'b1;
                arb_idx   = ID_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge axi_aclk) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (axi_reset) begin
            state        <= IDLE;
            rr_ptr       <= ID_WIDTH'(NUM_REQ - 1);
            grant_id     <= '0;
            done_id      <= '0;
            eng_sha_type <= '0;
            busy         <= 1'b0;
            msg_done     <= 1'b0;
            msg_count    <= '0;
        end else begin
            state    <= state_next;
            msg_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_found) begin
                        grant_id     <= arb_idx;
                        eng_sha_type <= req_sha[arb_idx];
                        busy         <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (wt_last_hs) begin
                        msg_done  <= 1'b1;
                        done_id   <= grant_id;
                        msg_count <= msg_count + 1'b1;
                        rr_ptr    <= grant_id;
                        busy      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        // NOTE: assigning a default first means no path through the case can infer a latch.
        state_next = state;
        case (state)
            IDLE:    if (arb_found) state_next = START;
            START:   state_next = STREAM;
            STREAM:  if (beat && bus.m_axis_tlast) state_next = DRAIN;
            DRAIN:   if (wt_last_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.m_axis_tdata  = req_data[grant_id];
        bus.m_axis_tvalid = 1'b0;
        bus.m_axis_tlast  = 1'b0;
        bus.eng_en        = 1'b0;
        ready_slot        = '0;
        case (state)
            START: bus.eng_en = 1'b1;
            STREAM: begin
                bus.m_axis_tvalid    = req_valid[grant_id];
                bus.m_axis_tlast     = req_last[grant_id];
                ready_slot[grant_id] = bus.m_axis_tready;
            end
            default: ;
        endcase
    end

    assign bus.s_axis_tready = ready_slot[NUM_REQ-1:0];
    assign bus.eng_sha_type  = eng_sha_type;
    assign bus.busy          = busy;
    assign bus.grant_id      = grant_id;
    assign bus.msg_done      = msg_done;
    assign bus.done_id       = done_id;
    assign bus.msg_count     = msg_count;
endmodule

// File: tb/tb_wt_scheduler.sv
// Self-checking bench for wt_scheduler: table-driven arbitration plus stream/done scoreboards
// and hand-written sequences for mid-message reset, stalls, drain hold and counter wrap.
module tb_wt_scheduler;
    localparam int NR = 4;
    localparam int DW = 512;
    localparam int IW = 2;
    localparam int CW = 3;

    typedef struct { logic [DW-1:0] data; logic last; } blk_t;
    typedef struct { logic [IW-1:0] id; logic [CW-1:0] count; } done_t;
    typedef struct { logic [NR-1:0] add; logic [IW-1:0] grant; logic [1:0] sha; } arb_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wt_scheduler_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW), .CNT_WIDTH(CW)) bus ();

    wt_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW), .CNT_WIDTH(CW)) dut (
        .axi_aclk (clk),
        .axi_reset(rst),
        .bus      (bus)
    );

    blk_t          req_q [NR][$];
    blk_t          exp_beat_q [$];
    done_t         exp_done_q [$];
    logic [1:0]    req_sha [NR];
    int            checks = 0;
    int            failures = 0;
    int            beats_seen = 0;
    int            done_seen = 0;
    int            msg_tag = 0;
    logic          last_seen = 1'b0;
    logic [CW-1:0] cnt_model = '0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input int r, input int tag, input int idx);
        logic [31:0] w;
        w = {8'(r), 8'(tag), 16'(idx)};
        return {16{w}};
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < NR; i++) begin
            bus.req_sha_type[2*i +: 2] = req_sha[i];
            if (req_q[i].size() != 0) begin
                bus.s_axis_tdata[i*DW +: DW] = req_q[i][0].data;
                bus.s_axis_tvalid[i]         = 1'b1;
                bus.s_axis_tlast[i]          = req_q[i][0].last;
            end else begin
                bus.s_axis_tdata[i*DW +: DW] = '0;
                bus.s_axis_tvalid[i]         = 1'b0;
                bus.s_axis_tlast[i]          = 1'b0;
            end
        end
    endtask

    task automatic enqueue(input int r, input int nblk, input bit push_exp);
        blk_t b;
        for (int j = 0; j < nblk; j++) begin
            b.data = mk_data(r, msg_tag, j);
            b.last = (j == nblk - 1);
            req_q[r].push_back(b);
            if (push_exp) exp_beat_q.push_back(b);
        end
        msg_tag++;
    endtask

    // One clock: score what the DUT shows before the edge, then advance the requester model.
    task automatic step();
        logic [NR-1:0] hs;
        blk_t          e;
        done_t         d;
        hs = bus.s_axis_tvalid & bus.s_axis_tready;
        if (bus.m_axis_tvalid === 1'b1 && bus.m_axis_tready === 1'b1) begin
            check("beat_expected", DW'(exp_beat_q.size() != 0), 1);
            if (exp_beat_q.size() != 0) begin
                e = exp_beat_q.pop_front();
                check("beat_data", bus.m_axis_tdata, e.data);
                check("beat_last", DW'(bus.m_axis_tlast), DW'(e.last));
            end
            beats_seen++;
            if (bus.m_axis_tlast) last_seen = 1'b1;
        end
        if (bus.msg_done === 1'b1) begin
            check("done_expected", DW'(exp_done_q.size() != 0), 1);
            if (exp_done_q.size() != 0) begin
                d = exp_done_q.pop_front();
                check("done_id", DW'(bus.done_id), DW'(d.id));
                check("msg_count", DW'(bus.msg_count), DW'(d.count));
                check("busy_clear", DW'(bus.busy), 0);
            end
            done_seen++;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++)
            if (hs[i] === 1'b1 && req_q[i].size() != 0) void'(req_q[i].pop_front());
        drive_reqs();
        #1;
    endtask

    task automatic wait_en();
        int n = 0;
        while (bus.eng_en !== 1'b1 && n < 16) begin
            step();
            n++;
        end
        check("en_seen", DW'(bus.eng_en), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_eng_en"},   DW'(bus.eng_en), 0);
        check({tag, "_busy"},     DW'(bus.busy), 0);
        check({tag, "_msg_done"}, DW'(bus.msg_done), 0);
        check({tag, "_m_tvalid"}, DW'(bus.m_axis_tvalid), 0);
        check({tag, "_s_tready"}, DW'(bus.s_axis_tready), 0);
        check({tag, "_grant_id"}, DW'(bus.grant_id), 0);
        check({tag, "_done_id"},  DW'(bus.done_id), 0);
        check({tag, "_sha"},      DW'(bus.eng_sha_type), 0);
        check({tag, "_count"},    DW'(bus.msg_count), 0);
    endtask

    // Wait for the final block, let the engine run briefly, then complete the W(t) stream.
    task automatic finish_msg(input logic [IW-1:0] id);
        int n = 0;
        int prev;
        while (!last_seen && n < 64) begin
            step();
            n++;
        end
        check("last_beat_seen", DW'(last_seen), 1);
        last_seen = 1'b0;
        step();
        step();
        cnt_model = cnt_model + 1'b1;
        exp_done_q.push_back('{id: id, count: cnt_model});
        prev = done_seen;
        bus.wt_tvalid = 1'b1;
        bus.wt_tready = 1'b1;
        bus.wt_tlast  = 1'b1;
        #1;
        step();
        bus.wt_tvalid = 1'b0;
        bus.wt_tready = 1'b0;
        bus.wt_tlast  = 1'b0;
        step();
        check("done_pulse", DW'(done_seen - prev), 1);
        check("done_one_cycle", DW'(bus.msg_done), 0);
    endtask

    initial begin
        arb_vec_t tbl [6];
        int       b0;
        int       n;

        req_sha = '{2'b10, 2'b11, 2'b01, 2'b00};
        tbl = '{
            '{4'b1111, 2'd0, 2'b10},
            '{4'b0000, 2'd1, 2'b11},
            '{4'b0000, 2'd2, 2'b01},
            '{4'b0000, 2'd3, 2'b00},
            '{4'b1001, 2'd0, 2'b10},
            '{4'b0000, 2'd3, 2'b00}
        };

        bus.m_axis_tready = 1'b1;
        bus.wt_tvalid     = 1'b0;
        bus.wt_tready     = 1'b0;
        bus.wt_tlast      = 1'b0;
        drive_reqs();
        rst = 1'b1;
        repeat (3) step();
        check_reset_outputs("rst");
        rst = 1'b0;
        step();

        // Reset during STREAM after one of two blocks abandons the message.
        enqueue(2, 2, 1'b1);
        drive_reqs();
        #1;
        wait_en();
        check("mr_grant", DW'(bus.grant_id), 2);
        step();
        step();
        check("mr_one_beat", DW'(beats_seen), 1);
        bus.m_axis_tready = 1'b0;
        rst = 1'b1;
        #1;
        step();
        check_reset_outputs("mr");
        rst = 1'b0;
        req_q[2].delete();
        exp_beat_q.delete();
        last_seen = 1'b0;
        bus.m_axis_tready = 1'b1;
        drive_reqs();
        #1;
        step();
        check("mr_no_done", DW'(done_seen), 0);

        // Round-robin order with all requesting, then a re-request from 0 and 3.
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NR; i++)
                if (tbl[k].add[i]) enqueue(i, 1, 1'b0);
            drive_reqs();
            #1;
            wait_en();
            check("arb_grant", DW'(bus.grant_id), DW'(tbl[k].grant));
            check("arb_sha", DW'(bus.eng_sha_type), DW'(tbl[k].sha));
            if (req_q[tbl[k].grant].size() != 0)
                exp_beat_q.push_back(req_q[tbl[k].grant][0]);
            finish_msg(tbl[k].grant);
        end

        // Three-block message from 1 with 0 waiting, plus a 5-cycle downstream stall.
        b0 = beats_seen;
        enqueue(1, 3, 1'b1);
        drive_reqs();
        #1;
        wait_en();
        check("s3_grant", DW'(bus.grant_id), 1);
        enqueue(0, 1, 1'b1);
        drive_reqs();
        #1;
        step();
        check("s3_ready", DW'(bus.s_axis_tready), 4'b0010);
        step();
        bus.m_axis_tready = 1'b0;
        #1;
        for (int j = 0; j < 5; j++) begin
            check("s3_stall_ready", DW'(bus.s_axis_tready), 0);
            check("s3_stall_valid", DW'(bus.m_axis_tvalid), 1);
            check("s3_no_done", DW'(bus.msg_done), 0);
            bus.wt_tvalid = (j == 2);
            bus.wt_tready = (j == 2);
            bus.wt_tlast  = (j == 2);
            step();
        end
        bus.m_axis_tready = 1'b1;
        #1;
        check("s3_resume_ready", DW'(bus.s_axis_tready), 4'b0010);
        finish_msg(1);
        check("s3_beats", DW'(beats_seen - b0), 3);

        // Hold wt_tlast with wt_tready low in DRAIN; this completion also wraps msg_count.
        wait_en();
        check("dr_grant", DW'(bus.grant_id), 0);
        n = 0;
        while (!last_seen && n < 64) begin
            step();
            n++;
        end
        check("dr_last_seen", DW'(last_seen), 1);
        last_seen = 1'b0;
        bus.wt_tvalid = 1'b1;
        bus.wt_tlast  = 1'b1;
        bus.wt_tready = 1'b0;
        #1;
        for (int j = 0; j < 10; j++) begin
            step();
            check("dr_no_done", DW'(bus.msg_done), 0);
            check("dr_busy", DW'(bus.busy), 1);
            check("dr_tvalid", DW'(bus.m_axis_tvalid), 0);
            check("dr_s_tready", DW'(bus.s_axis_tready), 0);
        end
        cnt_model = cnt_model + 1'b1;
        exp_done_q.push_back('{id: 2'd0, count: cnt_model});
        bus.wt_tready = 1'b1;
        #1;
        step();
        bus.wt_tvalid = 1'b0;
        bus.wt_tready = 1'b0;
        bus.wt_tlast  = 1'b0;
        check("dr_done", DW'(bus.msg_done), 1);
        check("count_wrap", DW'(bus.msg_count), 0);
        step();

        // Lone request from 2: en one cycle after request, lasting exactly one cycle.
        enqueue(2, 1, 1'b1);
        drive_reqs();
        #1;
        check("t1_en_before", DW'(bus.eng_en), 0);
        step();
        check("t1_en", DW'(bus.eng_en), 1);
        check("t1_grant", DW'(bus.grant_id), 2);
        check("t1_sha", DW'(bus.eng_sha_type), 2'b01);
        check("t1_busy", DW'(bus.busy), 1);
        check("t1_no_fwd", DW'(bus.m_axis_tvalid), 0);
        step();
        check("t1_en_once", DW'(bus.eng_en), 0);
        check("t1_ready", DW'(bus.s_axis_tready), 4'b0100);
        check("t1_fwd", DW'(bus.m_axis_tvalid), 1);
        finish_msg(2);
        check("t1_count", DW'(bus.msg_count), 1);
        check("t1_sha_held", DW'(bus.eng_sha_type), 2'b01);

        check("beats_drained", DW'(exp_beat_q.size()), 0);
        check("dones_drained", DW'(exp_done_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
